// File: rtl/conv1d_pkg.sv
// Shared types and helpers for the streaming 1-D convolution engine.
//   state_t    : sequencer states (LOAD, RUN, FLUSH)
//   clog2      : ceiling log2, usable in constant expressions
//   accWidth   : accumulator width, 2*DATA_W + clog2(TAPS)
//   saturate   : clamp a wide signed value to the signed range of outW bits
package conv1d_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Wide enough for any accumulator this block can be built with (DATA_W <= 60).
   localparam int SAT_W = 128;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int accWidth(input int dataW, input int taps);
      return 2 * dataW + clog2(taps);
   endfunction

   function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                        input int outW);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (SAT_W'(1) <<< (outW - 1)) - SAT_W'(1);
      lo = -hi - SAT_W'(1);
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage

// File: rtl/conv1d_tap.sv
// One weight-stationary processing element of the transposed-FIR array.
//   clk, rst        : clock, synchronous active-high reset
//   wLoad, wIn      : weight load enable and value
//   x               : sample broadcast to every tap
//   sumIn           : partial sum from the next-higher tap (0 for the last tap)
//   advance, clear  : partial-sum register update / clear
//   sum             : w*x + sumIn, registered when REGISTERED=1, combinational otherwise
// Tap 0 is built unregistered: its sum is the array result, and the top-level
// output register is the one pipeline stage behind it.
module conv1d_tap
   import conv1d_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ACC_W      = 70,
   parameter bit REGISTERED = 1'b1
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wLoad,
   input  logic signed [DATA_W-1:0] wIn,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [ACC_W-1:0]  sumIn,
   input  logic                     advance,
   input  logic                     clear,
   output logic signed [ACC_W-1:0]  sum
);

   logic signed [DATA_W-1:0] wReg;
   logic signed [ACC_W-1:0]  prod;
   logic signed [ACC_W-1:0]  sumNext;

   always_ff @(posedge clk) begin
      if (rst)
         wReg <= '0;
      else if (wLoad)
         wReg <= wIn;
   end

   // Product of two DATA_W values always fits in ACC_W, so the truncated multiply is exact.
   assign prod    = ACC_W'(wReg) * ACC_W'(x);
   assign sumNext = prod + sumIn;

   generate
      if (REGISTERED) begin : gReg
         logic signed [ACC_W-1:0] sReg;
         always_ff @(posedge clk) begin
            if (rst || clear)
               sReg <= '0;
            else if (advance)
               sReg <= sumNext;
         end
         assign sum = sReg;
      end else begin : gComb
         logic unusedCtl;
         assign unusedCtl = ^{advance, clear};
         assign sum = sumNext;
      end
   endgenerate

endmodule

// File: rtl/conv1d_stream_sys.sv
// Streaming 1-D linear convolution y[n] = sum_k w[k]*x[n-k], n = 0..N+K-2,
// over valid/ready streams with backpressure; weights reloadable between frames.
//   clk, rst                              : clock, synchronous active-high reset
//   w_valid, w_data, w_ready              : weight stream, w[0] first, TAPS words
//   reload                                : request new weights (honoured only when idle in RUN)
//   in_valid, in_data, in_last, in_ready  : sample stream, in_last on the final sample
//   out_valid, out_data, out_last, out_ready : result stream
//   busy                                  : frame in progress, flushing, or output pending
// Build option: define CONV1D_SATURATE_EN to clamp results to the OUT_W signed
// range; otherwise out_data is the low OUT_W bits of the result.
//
//   state | meaning
//   LOAD  | accepting TAPS weights, tap index widx
//   RUN   | accepting samples; one output per accepted sample
//   FLUSH | injecting zeros for the last TAPS-1 outputs, count fcnt
module conv1d_stream_sys
   import conv1d_pkg::*;
#(
   parameter int TAPS   = 10,
   parameter int DATA_W = 32,
   parameter int OUT_W  = 32
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w_valid,
   input  logic signed [DATA_W-1:0] w_data,
   output logic                     w_ready,
   input  logic                     reload,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_last,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     out_last,
   input  logic                     out_ready,
   output logic                     busy
);

   localparam int ACC_W = accWidth(DATA_W, TAPS);
   localparam int CNT_W = clog2(TAPS) + 1;

   state_t                  state;
   state_t                  stateNext;
   logic [CNT_W-1:0]        widx;
   logic [CNT_W-1:0]        widxNext;
   logic [CNT_W-1:0]        fcnt;
   logic [CNT_W-1:0]        fcntNext;
   logic                    frameActive;
   logic                    frameNext;

   logic                    adv;
   logic                    reloadOk;
   logic                    accept;
   logic                    flushStep;
   logic                    step;
   logic                    lastStep;
   logic                    clearS;
   logic signed [DATA_W-1:0] xIn;
   logic [TAPS-1:0]         wLoad;
   logic signed [ACC_W-1:0] sumChain [0:TAPS];
   logic signed [OUT_W-1:0] outNext;

   assign adv       = !out_valid || out_ready;
   assign reloadOk  = reload && (state == RUN) && !frameActive;
   assign accept    = in_valid && in_ready;
   assign flushStep = (state == FLUSH) && adv;
   assign step      = accept || flushStep;
   assign clearS    = flushStep && (fcnt == CNT_W'(1));
   assign lastStep  = (accept && in_last && (TAPS == 1)) || clearS;
   assign xIn       = accept ? in_data : '0;
   assign busy      = frameActive || (state == FLUSH) || out_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= LOAD;
         widx        <= '0;
         fcnt        <= '0;
         frameActive <= 1'b0;
      end else begin
         state       <= stateNext;
         widx        <= widxNext;
         fcnt        <= fcntNext;
         frameActive <= frameNext;
      end
   end

   always_comb begin
      stateNext = state;
      widxNext  = widx;
      fcntNext  = fcnt;
      frameNext = frameActive;
      w_ready   = 1'b0;
      in_ready  = 1'b0;
      case (state)
         LOAD: begin
            w_ready = 1'b1;
            if (w_valid) begin
               if (widx == CNT_W'(TAPS - 1)) begin
                  stateNext = RUN;
                  widxNext  = '0;
               end else begin
                  widxNext = widx + CNT_W'(1);
               end
            end
         end
         RUN: begin
            // A honoured reload wins over a sample offered in the same cycle.
            in_ready = adv && !reloadOk;
            if (reloadOk) begin
               stateNext = LOAD;
               widxNext  = '0;
            end else if (in_valid && adv) begin
               frameNext = 1'b1;
               if (in_last) begin
                  if (TAPS == 1) begin
                     frameNext = 1'b0;
                  end else begin
                     stateNext = FLUSH;
                     fcntNext  = CNT_W'(TAPS - 1);
                  end
               end
            end
         end
         FLUSH: begin
            if (adv) begin
               fcntNext = fcnt - CNT_W'(1);
               if (fcnt == CNT_W'(1)) begin
                  stateNext = RUN;
                  frameNext = 1'b0;
               end
            end
         end
         default: stateNext = LOAD;
      endcase
   end

   assign sumChain[TAPS] = '0;

   generate
      for (genvar k = 0; k < TAPS; k++) begin : gTap
         assign wLoad[k] = (state == LOAD) && w_valid && (widx == CNT_W'(k));
         conv1d_tap #(
            .DATA_W     (DATA_W),
            .ACC_W      (ACC_W),
            .REGISTERED (k != 0)
         ) uTap (
            .clk     (clk),
            .rst     (rst),
            .wLoad   (wLoad[k]),
            .wIn     (w_data),
            .x       (xIn),
            .sumIn   (sumChain[k+1]),
            .advance (step),
            .clear   (clearS),
            .sum     (sumChain[k])
         );
      end
   endgenerate

`ifdef CONV1D_SATURATE_EN
   assign outNext = OUT_W'(saturate(SAT_W'(sumChain[0]), OUT_W));
`else
   assign outNext = OUT_W'(sumChain[0]);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (step) begin
         out_valid <= 1'b1;
         out_data  <= outNext;
         out_last  <= lastStep;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv1d_stream_sys.sv
// Self-checking bench for conv1d_stream_sys (TAPS=3, DATA_W=8, OUT_W=8).
// Expected outputs come from a direct convolution over the sent frame and the
// current weight set, then wrapped or clamped to OUT_W to match the build.
module tb_conv1d_stream_sys;

   localparam int TAPS   = 3;
   localparam int DATA_W = 8;
   localparam int OUT_W  = 8;
   localparam int LIMIT  = 300;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     w_valid = 1'b0;
   logic signed [DATA_W-1:0] w_data = '0;
   logic                     w_ready;
   logic                     reload = 1'b0;
   logic                     in_valid = 1'b0;
   logic signed [DATA_W-1:0] in_data = '0;
   logic                     in_last = 1'b0;
   logic                     in_ready;
   logic                     out_valid;
   logic signed [OUT_W-1:0]  out_data;
   logic                     out_last;
   logic                     out_ready = 1'b1;
   logic                     busy;

   logic stallReq = 1'b0;
   logic randBp   = 1'b0;
   logic monOn    = 1'b1;

   int nChecks = 0;
   int nPass   = 0;

   typedef struct {
      longint data;
      bit     last;
   } expT;

   expT expQ[$];
   int  wModel[TAPS];

   conv1d_stream_sys #(
      .TAPS   (TAPS),
      .DATA_W (DATA_W),
      .OUT_W  (OUT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .w_valid   (w_valid),
      .w_data    (w_data),
      .w_ready   (w_ready),
      .reload    (reload),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      nChecks++;
      if (obs == exp)
         nPass++;
      else
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   function automatic longint fitOut(input longint y);
      longint span;
      longint m;
      span = longint'(1) << OUT_W;
`ifdef CONV1D_SATURATE_EN
      if (y > span / 2 - 1)
         return span / 2 - 1;
      else if (y < -(span / 2))
         return -(span / 2);
      else
         return y;
`else
      m = y & (span - 1);
      if (m >= span / 2)
         m = m - span;
      return m;
`endif
   endfunction

   function automatic void modelFrame(input int xs[$]);
      int  n;
      expT e;
      n = xs.size();
      for (int i = 0; i < n + TAPS - 1; i++) begin
         longint acc;
         acc = 0;
         for (int k = 0; k < TAPS; k++) begin
            if (i - k >= 0 && i - k < n)
               acc += longint'(wModel[k]) * longint'(xs[i-k]);
         end
         e.data = fitOut(acc);
         e.last = (i == n + TAPS - 2);
         expQ.push_back(e);
      end
   endfunction

   // Output ready: directed stall overrides, otherwise always-ready or random.
   always @(posedge clk) begin
      #2;
      out_ready = !stallReq && (!randBp || ($urandom_range(0, 3) != 0));
   end

   // Every valid output cycle (including stalled ones) must present the head of the queue.
   always @(negedge clk) begin
      if (monOn && !rst) begin
         if (out_valid) begin
            if (expQ.size() == 0) begin
               chk("spuriousOut", longint'(out_valid), 0);
            end else begin
               chk("outData", longint'(out_data), expQ[0].data);
               chk("outLast", longint'(out_last), longint'(expQ[0].last));
               if (out_ready)
                  void'(expQ.pop_front());
            end
            if (!out_ready)
               chk("inReadyStall", longint'(in_ready), 0);
         end
      end
   end

   task automatic loadWeights(input int ws[TAPS]);
      int n;
      wModel = ws;
      for (int i = 0; i < TAPS; i++) begin
         w_valid = 1'b1;
         w_data  = DATA_W'(ws[i]);
         n = 0;
         @(negedge clk);
         while (!w_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
         end
         if (!w_ready)
            chk("wReadyTimeout", longint'(w_ready), 1);
         @(posedge clk);
         #1;
      end
      w_valid = 1'b0;
   endtask

   task automatic sendFrame(input int xs[$], input bit gaps);
      int n;
      modelFrame(xs);
      for (int i = 0; i < xs.size(); i++) begin
         in_valid = 1'b1;
         in_data  = DATA_W'(xs[i]);
         in_last  = (i == xs.size() - 1);
         n = 0;
         @(negedge clk);
         while (!in_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
         end
         if (!in_ready)
            chk("inReadyTimeout", longint'(in_ready), 1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
         end
      end
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (expQ.size() != 0 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (expQ.size() != 0)
         chk("drainTimeout", longint'(expQ.size()), 0);
      @(negedge clk);
      chk("busyIdle", longint'(busy), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic doReload();
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
      @(negedge clk);
      chk("wReadyAfterReload", longint'(w_ready), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int xq[$];
      int rw[TAPS];

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstOutValid", longint'(out_valid), 0);
      chk("rstOutLast", longint'(out_last), 0);
      chk("rstOutData", longint'(out_data), 0);
      chk("rstBusy", longint'(busy), 0);
      chk("rstInReady", longint'(in_ready), 0);
      chk("rstWReady", longint'(w_ready), 1);
      @(posedge clk);
      #1;

      // Basic frame: 1,3,6,6,5,3
      loadWeights('{1, 2, 3});
      xq = '{1, 1, 1, 1};
      sendFrame(xq, 1'b0);
      waitDrain();

      // Two single-sample frames back to back: 5,10,15 twice
      xq = '{5};
      sendFrame(xq, 1'b0);
      sendFrame(xq, 1'b0);
      waitDrain();

      // Directed 3-cycle output stall mid-frame
      xq = '{3, -1, 4, 1, -5, 9};
      fork
         sendFrame(xq, 1'b0);
         begin
            repeat (3) @(posedge clk);
            #1;
            stallReq = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            stallReq = 1'b0;
         end
      join
      waitDrain();

      // Reload mid-frame must be ignored
      xq = '{2, 7, 1, 8, 2};
      fork
         sendFrame(xq, 1'b0);
         begin
            repeat (2) @(posedge clk);
            #1;
            reload = 1'b1;
            @(posedge clk);
            #1;
            reload = 1'b0;
            @(negedge clk);
            chk("wReadyMidFrame", longint'(w_ready), 0);
         end
      join
      waitDrain();

      // Reload between frames: w=[1,1,1], x=[2,2] -> 2,4,4,2
      doReload();
      loadWeights('{1, 1, 1});
      xq = '{2, 2};
      sendFrame(xq, 1'b0);
      waitDrain();

      // Signed path: -6,8,3,-4
      doReload();
      loadWeights('{-2, 0, 1});
      xq = '{3, -4};
      sendFrame(xq, 1'b0);
      waitDrain();

      // Overflow: wrap gives 1,2,2,1; saturate gives 127 x4
      doReload();
      loadWeights('{127, 127, 127});
      xq = '{127, 127};
      sendFrame(xq, 1'b0);
      waitDrain();

      // Reset mid-frame aborts without output and requires a weight reload
      monOn    = 1'b0;
      in_valid = 1'b1;
      in_last  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data = DATA_W'(i + 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midRstOutValid", longint'(out_valid), 0);
      chk("midRstBusy", longint'(busy), 0);
      chk("midRstWReady", longint'(w_ready), 1);
      chk("midRstInReady", longint'(in_ready), 0);
      @(posedge clk);
      #1;
      monOn = 1'b1;

      // Randomized frames, weights and backpressure
      randBp = 1'b1;
      for (int f = 0; f < 16; f++) begin
         if (f == 0 || $urandom_range(0, 1) == 1) begin
            if (f != 0)
               doReload();
            for (int k = 0; k < TAPS; k++)
               rw[k] = int'($urandom_range(0, 255)) - 128;
            loadWeights(rw);
         end
         xq.delete();
         repeat ($urandom_range(1, 10))
            xq.push_back(int'($urandom_range(0, 255)) - 128);
         sendFrame(xq, 1'b1);
         if ($urandom_range(0, 1) == 1) begin
            xq.delete();
            repeat ($urandom_range(1, 4))
               xq.push_back(int'($urandom_range(0, 255)) - 128);
            sendFrame(xq, 1'b0);
         end
         waitDrain();
      end
      randBp = 1'b0;

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", nPass, nChecks);
      $fatal(1);
   end

endmodule
